// File: rtl/mips_cache_pkg.sv
// mips_cache_pkg: shared FSM state type and address-field width helpers
package mips_cache_pkg;
   typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM} state_t;
   localparam int OFF_W = 2;
   function automatic int tag_w(input int set_bits);
      return 32 - set_bits - OFF_W;
   endfunction
   function automatic int sets(input int set_bits);
      return 1 << set_bits;
   endfunction
endpackage

// File: rtl/mips_cache_assoc_if.sv
// mips_cache_assoc_if: CPU-side and memory-side bus of the write-through cache
interface mips_cache_assoc_if;
   logic [31:0] addr;
   logic        read_en;
   logic        write_en;
   logic [31:0] writedata;
   logic [3:0]  byte_en;
   logic [31:0] readdata;
   logic        stall;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_readdata;
   logic        mem_ack;
   logic        invalidate_all;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   modport slave (
      input  addr, read_en, write_en, writedata, byte_en, mem_readdata, mem_ack, invalidate_all,
      output readdata, stall, mem_addr, mem_read, mem_write, mem_writedata, mem_byte_en,
             hit_count, miss_count
   );
   modport master (
      output addr, read_en, write_en, writedata, byte_en, mem_readdata, mem_ack, invalidate_all,
      input  readdata, stall, mem_addr, mem_read, mem_write, mem_writedata, mem_byte_en,
             hit_count, miss_count
   );
endinterface

// File: rtl/mips_cache_plru.sv
// mips_cache_plru: per-set tree pseudo-LRU victim selection and access update
module mips_cache_plru
   import mips_cache_pkg::*;
#(
   parameter int WAYS     = 4,
   parameter int SET_BITS = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SET_BITS-1:0]      idx,
   input  logic                     upd,
   input  logic [$clog2(WAYS)-1:0]  upd_way,
   output logic [$clog2(WAYS)-1:0]  victim
);
   localparam int LW = $clog2(WAYS);
   localparam int SETS = sets(SET_BITS);
   // node j (1-based heap order) lives at bit j-1; a 0 sends the victim search left
   logic [WAYS-2:0] tree_q [SETS];
   logic [WAYS-2:0] cur;
   logic [WAYS-2:0] tree_n;
   // walk the tree for the victim, and mark the accessed path as most recently used
   always_comb begin
      int n;
      logic b;
      cur = tree_q[idx];
      tree_n = cur;
      victim = '0;
      n = 1;
      for (int l = 0; l < LW; l++) begin
         b = 1'b0;
         for (int j = 1; j < WAYS; j++) if (j == n) b = cur[j-1];
         victim[LW-1-l] = b;
         n = 2 * n + (b ? 1 : 0);
      end
      n = 1;
      for (int l = 0; l < LW; l++) begin
         for (int j = 1; j < WAYS; j++) if (j == n) tree_n[j-1] = ~upd_way[LW-1-l];
         n = 2 * n + (upd_way[LW-1-l] ? 1 : 0);
      end
   end
   // tree bits clear on reset and follow every hit or fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
      else if (upd) tree_q[idx] <= tree_n;
   end
endmodule

// File: rtl/mips_cache_assoc.sv
// mips_cache_assoc: set-associative write-through, no-write-allocate one-word-line cache
module mips_cache_assoc
   import mips_cache_pkg::*;
#(
   parameter int WAYS     = 4,
   parameter int SET_BITS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   mips_cache_assoc_if.slave  bus
);
   localparam int SETS = sets(SET_BITS);
   localparam int TW   = tag_w(SET_BITS);
   localparam int LW   = $clog2(WAYS);
   logic [TW-1:0]       tag_q   [SETS][WAYS];
   logic [31:0]         data_q  [SETS][WAYS];
   logic [WAYS-1:0]     valid_q [SETS];
   state_t              state;
   logic [SET_BITS-1:0] idx;
   logic [TW-1:0]       tag;
   logic                hit, inv_any;
   logic [LW-1:0]       hit_way, inv_way, plru_victim, victim, plru_way;
   logic [31:0]         hit_data, merged;
   logic                rd_hit, fill, wr_hit, plru_upd;
   assign idx = bus.addr[SET_BITS+OFF_W-1:OFF_W];
   assign tag = bus.addr[31:SET_BITS+OFF_W];
   assign bus.mem_addr = {bus.addr[31:2], 2'b00};
   // tag match and lowest free way; the descending scan leaves the lowest index
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit = 1'b1;
            hit_way = LW'(w);
         end
         if (!valid_q[idx][w]) begin
            inv_any = 1'b1;
            inv_way = LW'(w);
         end
      end
   end
   assign victim   = inv_any ? inv_way : plru_victim;
   assign hit_data = data_q[idx][hit_way];
   // byte-lane merge of a write-through store into the cached word
   always_comb begin
      merged = hit_data;
      for (int b = 0; b < 4; b++) if (bus.byte_en[b]) merged[8*b +: 8] = bus.writedata[8*b +: 8];
   end
   assign rd_hit   = state == IDLE && !bus.invalidate_all && !bus.write_en && bus.read_en && hit;
   assign fill     = state == RD_MISS && bus.mem_ack;
   assign wr_hit   = state == WR_MEM && bus.mem_ack && hit;
   assign plru_upd = rd_hit || fill || wr_hit;
   assign plru_way = fill ? victim : hit_way;
   assign bus.stall = state == IDLE
                    ? (bus.read_en || bus.write_en) && (bus.invalidate_all || bus.write_en || !hit)
                    : !bus.mem_ack;
   mips_cache_plru #(.WAYS(WAYS), .SET_BITS(SET_BITS)) u_plru (
      .clk     (clk),
      .rst_n   (rst_n),
      .idx     (idx),
      .upd     (plru_upd),
      .upd_way (plru_way),
      .victim  (plru_victim)
   );
   // tag and data storage need no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q[idx][victim]  <= tag;
         data_q[idx][victim] <= bus.mem_readdata;
      end else if (wr_hit) data_q[idx][hit_way] <= merged;
   end
   // valid bits: flash clear on invalidate in IDLE, set on fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      else if (state == IDLE && bus.invalidate_all) for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      else if (fill) valid_q[idx][victim] <= 1'b1;
   end
   // control FSM with registered memory strobes, read data and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         bus.mem_read      <= 1'b0;
         bus.mem_write     <= 1'b0;
         bus.mem_writedata <= '0;
         bus.mem_byte_en   <= '0;
         bus.readdata      <= '0;
         bus.hit_count     <= '0;
         bus.miss_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.invalidate_all && bus.write_en) begin
                  state             <= WR_MEM;
                  bus.mem_write     <= 1'b1;
                  bus.mem_writedata <= bus.writedata;
                  bus.mem_byte_en   <= bus.byte_en;
               end else if (!bus.invalidate_all && bus.read_en && hit) begin
                  bus.readdata  <= hit_data;
                  bus.hit_count <= bus.hit_count + {31'b0, bus.hit_count != '1};
               end else if (!bus.invalidate_all && bus.read_en) begin
                  state          <= RD_MISS;
                  bus.mem_read   <= 1'b1;
                  bus.miss_count <= bus.miss_count + {31'b0, bus.miss_count != '1};
               end
            end
            RD_MISS: begin
               if (bus.mem_ack) begin
                  state        <= IDLE;
                  bus.mem_read <= 1'b0;
                  bus.readdata <= bus.mem_readdata;
               end
            end
            WR_MEM: begin
               if (bus.mem_ack) begin
                  state         <= IDLE;
                  bus.mem_write <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
